fx2_slave_fifo_responder: RTL

- Synthesizable FX2LP slave-FIFO device-side responder: the endpoint that answers the FPGA-side master which drives SLWR/SLRD/SLOE/FIFOADR and samples FLAGA/FLAGD.
- Holds an EP2 OUT buffer (host→FPGA) and an EP6 IN buffer (FPGA→host), drives FD on reads and absorbs FD on writes.
- A host-side stream port fills EP2 and drains EP6.
- Used as the emulation/verification counterpart of the USB master and for loopback bring-up without the FX2 part.

---
 rtl/usb_fx2_pkg.sv | 29 ++
 rtl/usb_ep_fifo.sv | 63 ++++++
 rtl/fx2_slave_fifo_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/usb_fx2_pkg.sv
// ============================================================================
// usb_fx2_pkg : shared constants and types for the FX2 slave-FIFO responder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package usb_fx2_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] ADR_EP2 = 2'b00;
  localparam logic [1:0] ADR_EP4 = 2'b01;
  localparam logic [1:0] ADR_EP6 = 2'b10;
  localparam logic [1:0] ADR_EP8 = 2'b11;

  typedef enum logic [1:0] {
    BUS_HIZ   = 2'd0,
    BUS_DRIVE = 2'd1,
    BUS_TURN  = 2'd2
  } bus_state_e;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_BADADR   = 2;

endpackage

`default_nettype wire

// File: rtl/usb_ep_fifo.sv
// ============================================================================
// usb_ep_fifo : synchronous first-word-fall-through endpoint buffer with level
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module usb_ep_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     head_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int               DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally; the extra level bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fx2_slave_fifo_responder.sv
// ============================================================================
// fx2_slave_fifo_responder : FX2LP slave-FIFO device side (EP2 OUT / EP6 IN)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fx2_slave_fifo_responder #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 16
) (
  input  logic                  CLKOUT,
  input  logic                  rst,
  output logic                  FLAGA,
  output logic                  FLAGD,
  input  logic                  SLWR,
  input  logic                  SLRD,
  input  logic                  SLOE,
  input  logic [1:0]            FIFOADR,
  inout  wire  [DATA_W-1:0]     FD,
  input  logic                  h_out_valid,
  input  logic [DATA_W-1:0]     h_out_data,
  output logic                  h_out_ready,
  output logic                  h_in_valid,
  output logic [DATA_W-1:0]     h_in_data,
  input  logic                  h_in_ready,
  output logic [DEPTH_LOG2:0]   ep2_level,
  output logic [DEPTH_LOG2:0]   ep6_level,
  output logic [2:0]            err
);

  import usb_fx2_pkg::*;

  bus_state_e        state_q, state_d;
  logic [DATA_W-1:0] last_q, ep2_head, fd_word;
  logic [2:0]        err_q, err_d;
  logic              ep2_empty, ep2_full, ep6_empty, ep6_full;
  logic              rd_req, wr_req, sel_ep2, sel_ep6;
  logic              ep2_push, ep2_pop, ep6_push, ep6_pop;

  assign rd_req  = ~SLRD;
  assign wr_req  = ~SLWR;
  assign sel_ep2 = (FIFOADR == ADR_EP2);
  assign sel_ep6 = (FIFOADR == ADR_EP6);

  // A write strobe during DRIVE is bus contention and must not reach EP6.
  assign ep2_pop  = rd_req && sel_ep2 && !ep2_empty;
  assign ep6_push = wr_req && sel_ep6 && !ep6_full && (state_q != BUS_DRIVE);
  assign ep2_push = h_out_valid && !ep2_full;
  assign ep6_pop  = h_in_ready && !ep6_empty;

  usb_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_ep2 (
    .clk(CLKOUT), .rst(rst),
    .push_i(ep2_push), .push_data_i(h_out_data), .pop_i(ep2_pop),
    .head_o(ep2_head), .level_o(ep2_level), .empty_o(ep2_empty), .full_o(ep2_full)
  );

  usb_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_ep6 (
    .clk(CLKOUT), .rst(rst),
    .push_i(ep6_push), .push_data_i(FD), .pop_i(ep6_pop),
    .head_o(h_in_data), .level_o(ep6_level), .empty_o(ep6_empty), .full_o(ep6_full)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      BUS_HIZ:   if (!SLOE && sel_ep2) state_d = BUS_DRIVE;
      BUS_DRIVE: if (SLOE || !sel_ep2) state_d = BUS_TURN;
      BUS_TURN:  state_d = BUS_HIZ;
      default:   state_d = BUS_HIZ;
    endcase
    if (rd_req && sel_ep2 && ep2_empty) err_d[ERR_UNDERRUN] = 1'b1;
    if (wr_req && sel_ep6 && ep6_full)  err_d[ERR_OVERRUN]  = 1'b1;
    if ((rd_req && !sel_ep2) || (wr_req && !sel_ep6) ||
        (wr_req && (state_q == BUS_DRIVE)))
      err_d[ERR_BADADR] = 1'b1;
  end

  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      state_q <= BUS_HIZ;
      err_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (ep2_pop) last_q <= ep2_head;
    end
  end

  // With EP2 drained the bus keeps showing the most recently popped word.
  assign fd_word     = ep2_empty ? last_q : ep2_head;
  assign FD          = (state_q == BUS_DRIVE) ? fd_word : {DATA_W{1'bz}};
  assign FLAGA       = !ep2_empty;
  assign FLAGD       = !ep6_full;
  assign h_out_ready = !ep2_full;
  assign h_in_valid  = !ep6_empty;
  assign err         = err_q;

endmodule

`default_nettype wire
